// File: rtl/pc_gen_pkg.sv
// Shared types and default constants for the fetch-side program-counter generator.
package pc_pkg;

  // Width of the pending-slot target field; the PC generator is instantiated at this XLEN.
  localparam int PC_XLEN = 32;

  localparam logic [PC_XLEN-1:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [PC_XLEN-1:0] PC_TRAP_VEC_DEF  = 32'h0000_0100;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  // One-deep holding slot for a redirect/trap that arrives while a fetch is stalled.
  typedef struct packed {
    logic               valid;
    logic               is_trap;
    logic [PC_XLEN-1:0] target;
  } pc_pending_t;

  // True when addr has any bit set below the instruction-size alignment.
  function automatic logic pc_misaligned(logic [PC_XLEN-1:0] addr, int ilen_bytes);
    logic [PC_XLEN-1:0] mask;
    mask = PC_XLEN'(ilen_bytes - 1);
    return (addr & mask) != '0;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request channel: address with a valid/ready handshake.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;

  modport master (
    output req_valid,
    output req_pc,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    output req_ready
  );

endinterface

// File: rtl/pc_gen_redirect_arb.sv
// Next-PC arbitration: trap / misaligned redirect / redirect / pending slot / sequential / hold,
// plus the one-entry pending slot that parks events arriving during a stalled fetch.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int              XLEN       = PC_XLEN,
  parameter int              ILEN_BYTES = 4,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(PC_TRAP_VEC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            stall,
  input  logic            accept,
  input  logic [XLEN-1:0] pc_cur,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign_err
);

  logic        misalign;
  logic        event_trap;
  logic        event_redir;
  pc_pending_t pend_q;
  pc_pending_t pend_d;

  // A misaligned redirect is discarded and promoted to a trap.
  assign misalign    = redirect_valid && pc_misaligned(PC_XLEN'(redirect_target), ILEN_BYTES);
  assign event_trap  = trap_valid || misalign;
  assign event_redir = redirect_valid && !misalign;

  // Priority select of the next PC and next slot contents.
  always_comb begin
    pend_d  = pend_q;
    pc_next = pc_cur;
    if (stall) begin
      // Request outstanding: PC must hold, so park the event. A redirect never displaces a trap.
      if (event_trap) begin
        pend_d.valid   = 1'b1;
        pend_d.is_trap = 1'b1;
        pend_d.target  = PC_XLEN'(TRAP_VEC);
      end else if (event_redir && !(pend_q.valid && pend_q.is_trap)) begin
        pend_d.valid   = 1'b1;
        pend_d.is_trap = 1'b0;
        pend_d.target  = PC_XLEN'(redirect_target);
      end
    end else begin
      // Nothing outstanding (or accepting now): new events load the PC directly, slot drains.
      pend_d.valid   = 1'b0;
      pend_d.is_trap = 1'b0;
      if (event_trap) begin
        pc_next = TRAP_VEC;
      end else if (event_redir) begin
        pc_next = redirect_target;
      end else if (accept) begin
        pc_next = pend_q.valid ? XLEN'(pend_q.target) : pc_plus4;
      end
    end
  end

  // Pending slot register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Misalignment flag, one cycle after the offending redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misalign;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch front end: BOOT/RUN/HALT control, PC register
// and the fetch-request handshake. Next-PC selection lives in pc_redirect_arb.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = PC_XLEN,
  parameter int              ILEN_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(PC_TRAP_VEC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            halt,
  input  logic            resume,
  pc_gen_if.master        fetch,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err,
  output logic            halted
);

  pc_state_e       state_q;
  pc_state_e       state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            req_valid_w;
  logic            halted_w;
  logic            stall;
  logic            accept;

  assign stall    = req_valid_w && !fetch.req_ready;
  assign accept   = req_valid_w && fetch.req_ready;
  assign pc_plus4 = pc_q + XLEN'(ILEN_BYTES);

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PC_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: halt waits for any outstanding request to be accepted; halt beats resume.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN:  if (halt && !stall) state_d = PC_HALT;
      PC_HALT: if (resume && !halt) state_d = PC_RUN;
      default: state_d = PC_BOOT;
    endcase
  end

  // State decode to fetch-valid and halted indications.
  always_comb begin
    req_valid_w = 1'b0;
    halted_w    = 1'b0;
    case (state_q)
      PC_RUN:  req_valid_w = 1'b1;
      PC_HALT: halted_w    = 1'b1;
      default: ;
    endcase
  end

  pc_redirect_arb #(
    .XLEN       (XLEN),
    .ILEN_BYTES (ILEN_BYTES),
    .TRAP_VEC   (TRAP_VEC)
  ) u_arb (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .stall           (stall),
    .accept          (accept),
    .pc_cur          (pc_q),
    .pc_plus4        (pc_plus4),
    .pc_next         (pc_d),
    .misalign_err    (misalign_err)
  );

  // PC register; the arbiter already holds it while a request is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out          = pc_q;
  assign halted          = halted_w;
  assign fetch.req_valid = req_valid_w;
  assign fetch.req_pc    = pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Randomized scoreboard bench for pc_gen against a cycle-level behavioural model.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_1000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        trap_valid = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic        halted;

  pc_gen_if #(.XLEN(32)) fetch_if ();

  pc_gen #(
    .XLEN       (32),
    .ILEN_BYTES (4),
    .RESET_VEC  (RV),
    .TRAP_VEC   (TV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .halt            (halt),
    .resume          (resume),
    .fetch           (fetch_if),
    .pc_out          (pc_out),
    .pc_plus4        (pc_plus4),
    .misalign_err    (misalign_err),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        mis;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state
  int          m_mode;
  logic [31:0] m_pc;
  bit          m_mis;
  bit          p_v;
  bit          p_trap;
  logic [31:0] p_tgt;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT;
    m_pc   = RV;
    m_mis  = 0;
    p_v    = 0;
    p_trap = 0;
    p_tgt  = '0;
  endtask

  // One clock of the fetch front end, in terms of the documented rules.
  task automatic model_step(bit rv, logic [31:0] rt, bit tv, bit h, bit rs, bit rdy);
    bit fetching, stalled, accepted, mis, trap, redir;
    fetching = (m_mode == M_RUN);
    stalled  = fetching && !rdy;
    accepted = fetching && rdy;
    mis      = rv && ((rt % 4) != 0);
    trap     = tv || mis;
    redir    = rv && !mis;
    if (stalled) begin
      if (trap) begin
        p_v = 1; p_trap = 1; p_tgt = TV;
      end else if (redir && !(p_v && p_trap)) begin
        p_v = 1; p_trap = 0; p_tgt = rt;
      end
    end else begin
      if (trap)          m_pc = TV;
      else if (redir)    m_pc = rt;
      else if (accepted) m_pc = p_v ? p_tgt : m_pc + 32'd4;
      p_v = 0; p_trap = 0;
    end
    case (m_mode)
      M_BOOT:  m_mode = M_RUN;
      M_RUN:   if (h && !stalled) m_mode = M_HALT;
      default: if (rs && !h) m_mode = M_RUN;
    endcase
    m_mis = mis;
  endtask

  task automatic drive(bit rv, logic [31:0] rt, bit tv, bit h, bit rs, bit rdy);
    exp_t e;
    @(negedge clk);
    rst               = 1'b1;
    redirect_valid    = rv;
    redirect_target   = rt;
    trap_valid        = tv;
    halt              = h;
    resume            = rs;
    fetch_if.req_ready = rdy;
    model_step(rv, rt, tv, h, rs, rdy);
    e.vld = (m_mode == M_RUN);
    e.pc  = m_pc;
    e.mis = m_mis;
    e.hlt = (m_mode == M_HALT);
    sb.push_back(e);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_req_valid", 32'(fetch_if.req_valid), 32'd0);
    check("rst_pc_out", pc_out, RV);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    model_reset();
    redirect_valid = 0; trap_valid = 0; halt = 0; resume = 0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every clock with an outstanding expectation, compare DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("req_valid", 32'(fetch_if.req_valid), 32'(e.vld));
        check("pc_out", pc_out, e.pc);
        check("req_pc", fetch_if.req_pc, e.pc);
        check("pc_plus4", pc_plus4, e.pc + 32'd4);
        check("misalign_err", 32'(misalign_err), 32'(e.mis));
        check("halted", 32'(halted), 32'(e.hlt));
      end
    end
  end

  initial begin
    bit h_lvl;
    logic [31:0] t;
    fetch_if.req_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("init_req_valid", 32'(fetch_if.req_valid), 32'd0);
    check("init_pc_out", pc_out, RV);

    // Boot and sequential fetch
    repeat (4) drive(0, '0, 0, 0, 0, 1);
    // Stall at 0x20 with a late redirect to 0x400
    drive(1, 32'h20, 0, 0, 0, 1);
    drive(1, 32'h400, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    // Trap + redirect while stalled; a later redirect must not displace the trap
    drive(1, 32'h80, 1, 0, 0, 0);
    drive(1, 32'h300, 0, 0, 0, 0);
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    // Same-cycle trap + redirect with no stall
    drive(1, 32'h80, 1, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    // Misaligned redirect
    drive(1, 32'h402, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    // Halt during a stalled request at 0x40, redirect while halted, resume
    drive(1, 32'h40, 0, 0, 0, 1);
    drive(0, '0, 0, 1, 0, 0);
    drive(0, '0, 0, 1, 0, 0);
    drive(0, '0, 0, 1, 0, 1);
    drive(0, '0, 0, 1, 0, 1);
    drive(1, 32'h800, 0, 1, 0, 1);
    drive(0, '0, 0, 1, 1, 1);
    drive(0, '0, 0, 0, 1, 1);
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    // Wrap-around, then reset in the middle of a stall
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 1);
    drive(0, '0, 0, 0, 0, 0);
    drive(1, 32'h600, 0, 0, 0, 0);
    do_reset();
    repeat (3) drive(0, '0, 0, 0, 0, 1);

    // Randomized traffic
    h_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) h_lvl = !h_lvl;
      t = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
      drive($urandom_range(0, 5) == 0, t, $urandom_range(0, 14) == 0, h_lvl,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
      if (i == 1500) begin
        do_reset();
        h_lvl = 0;
      end
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
